// File: rtl/instr_queue_if.sv
// Fetch-side and issue-side signals of the instruction queue.
// The queue itself connects through master; fetch/issue logic (or a bench) connects through slave.
interface instr_queue_if #(
  parameter int DEPTH = 8
) ();
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      fetch_instr;
  logic [31:0]      fetch_pc;
  logic [2:0]       fetch_pc_save;
  logic [31:0]      fetch_target_predict;
  logic             iq_assert;
  logic             iq_read;
  logic [4:0]       rd;
  logic [4:0]       r1_i;
  logic [4:0]       r2_i;
  logic [6:0]       opcode_i;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      src2_i;
  logic [31:0]      b_imm;
  logic [31:0]      j_imm;
  logic [31:0]      inst_pc;
  logic [31:0]      instruction_i;
  logic [2:0]       pc_save;
  logic [31:0]      target_predict_i;
  logic [PTR_W:0]   count;

  modport master (
    input  flush, fetch_valid, fetch_instr, fetch_pc, fetch_pc_save,
           fetch_target_predict, iq_read,
    output fetch_ready, iq_assert, rd, r1_i, r2_i, opcode_i, funct3, funct7,
           src2_i, b_imm, j_imm, inst_pc, instruction_i, pc_save,
           target_predict_i, count
  );

  modport slave (
    output flush, fetch_valid, fetch_instr, fetch_pc, fetch_pc_save,
           fetch_target_predict, iq_read,
    input  fetch_ready, iq_assert, rd, r1_i, r2_i, opcode_i, funct3, funct7,
           src2_i, b_imm, j_imm, inst_pc, instruction_i, pc_save,
           target_predict_i, count
  );
endinterface

// File: rtl/instr_queue.sv
// In-order instruction queue feeding Tomasulo issue: buffers fetched instructions
// and presents the head entry decoded into register indices and immediates.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_queue_if.master q
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_ACCEL = 7'b0001011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  pc_save;
    logic [31:0] target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PTR_W:0]  head_q, head_d;
  logic [PTR_W:0]  tail_q, tail_d;
  logic            empty, full, push, pop;
  entry_t          head_e;
  logic [31:0]     ins;
  logic [31:0]     i_imm, s_imm, u_imm, b_val, j_val;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);

  // Full refuses the push even if a pop happens this cycle, so fetch_ready never depends on iq_read.
  assign push = q.fetch_valid && !full && !q.flush;
  assign pop  = q.iq_read && !empty && !q.flush;

  assign q.fetch_ready = !full;
  assign q.iq_assert   = !empty;
  assign q.count       = tail_q - head_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (q.flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage holds no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q[PTR_W-1:0]] <= '{instr:   q.fetch_instr,
                                   pc:      q.fetch_pc,
                                   pc_save: q.fetch_pc_save,
                                   target:  q.fetch_target_predict};
    end
  end

  assign head_e = mem_q[head_q[PTR_W-1:0]];
  assign ins    = head_e.instr;

  assign i_imm = {{20{ins[31]}}, ins[31:20]};
  assign s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign u_imm = {ins[31:12], 12'b0};
  assign b_val = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign j_val = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    q.rd               = '0;
    q.r1_i             = '0;
    q.r2_i             = '0;
    q.opcode_i         = '0;
    q.funct3           = '0;
    q.funct7           = '0;
    q.src2_i           = '0;
    q.b_imm            = '0;
    q.j_imm            = '0;
    q.inst_pc          = '0;
    q.instruction_i    = '0;
    q.pc_save          = '0;
    q.target_predict_i = '0;
    if (!empty) begin
      q.opcode_i         = ins[6:0];
      q.funct3           = ins[14:12];
      q.funct7           = ins[31:25];
      q.b_imm            = b_val;
      q.j_imm            = j_val;
      q.inst_pc          = head_e.pc;
      q.instruction_i    = ins;
      q.pc_save          = head_e.pc_save;
      q.target_predict_i = head_e.target;
      q.rd               = ins[11:7];
      q.r1_i             = ins[19:15];
      case (ins[6:0])
        OP_IMM, OP_LOAD, OP_JALR: q.src2_i = i_imm;
        OP_ACCEL: begin
          q.src2_i = i_imm;
          q.r2_i   = ins[24:20];
        end
        OP_STORE: begin
          q.src2_i = s_imm;
          q.rd     = '0;
          q.r2_i   = ins[24:20];
        end
        OP_LUI, OP_AUIPC: begin
          q.src2_i = u_imm;
          q.r1_i   = '0;
        end
        OP_JAL: begin
          q.src2_i = j_val;
          q.r1_i   = '0;
        end
        OP_BR: begin
          q.src2_i = b_val;
          q.rd     = '0;
          q.r2_i   = ins[24:20];
        end
        // Register ops and unrecognised opcodes share the R-type field layout.
        default: q.r2_i = ins[24:20];
      endcase
    end
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- In-order instruction queue that feeds the Tomasulo issue stage.
- It is the producer side of the iq_assert/iq_read handshake: it buffers fetched instructions with their PC and prediction metadata, then presents the head entry as decoded fields (rd, r1, r2, opcode, funct3, funct7, immediates).
- Issue logic pops one entry per cycle by asserting iq_read; a flush from the ROB empties the queue.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; the pointers carry one extra wrap bit.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  ROB mispredict flush; empties the queue
- fetch_valid  input  1  fetch presents an instruction
- fetch_ready  output  1  queue can accept an instruction this cycle
- fetch_instr  input  32  raw instruction word
- fetch_pc  input  32  instruction PC
- fetch_pc_save  input  3  branch-history/PC tag forwarded to the ROB
- fetch_target_predict  input  32  predicted target (jalr/branch)
- iq_assert  output  1  head entry valid
- iq_read  input  1  issue consumes the head entry
- rd  output  5  destination register
- r1_i  output  5  source register 1
- r2_i  output  5  source register 2
- opcode_i  output  7  rv32i_opcode of head
- funct3  output  3
- funct7  output  7
- src2_i  output  32  selected immediate
- b_imm  output  32
- j_imm  output  32
- inst_pc  output  32
- instruction_i  output  32
- pc_save  output  3
- target_predict_i  output  32
- count  output  PTR_W+1  occupancy

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous and active-low.
- Reset:
  - head, tail and count are cleared to 0.
  - iq_assert = 0 and fetch_ready = 1.
  - All decoded outputs read 0.
- Storage:
  - Each entry holds {instr, pc, pc_save, target_predict}.
  - Entry contents are not reset; only the pointers are.
- Status flags:
  - empty = (head == tail).
  - full = (head and tail index bits equal, wrap bits differ).
  - count = tail - head, computed modulo 2^(PTR_W+1).
  - fetch_ready = !full. It has no combinational dependence on iq_read, so there is no loop through issue.
  - iq_assert = !empty.
- Push: on fetch_valid && fetch_ready, write the entry at tail and increment tail.
- Pop: on iq_assert && iq_read, increment head. iq_read while empty is ignored.
- Simultaneous push and pop, not full: both occur and count is unchanged.
  - When empty, a push is not visible on iq_assert until the next cycle. There is no bypass; latency is 1 cycle from fetch to iq_assert.
- Full: fetch_ready = 0 and fetch_valid is ignored, even if iq_read pops in the same cycle.
- Flush (synchronous, highest priority):
  - head, tail and count are cleared to 0 on that edge.
  - A push and/or pop in the same cycle is discarded.
  - iq_assert = 0 the following cycle.
- Reset mid-operation: the asynchronous clear takes effect immediately, regardless of clk.
- Decode (combinational from the head entry; all outputs are forced to 0 when empty):
  - opcode_i = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
  - b_imm and j_imm are always the sign-extended RV32I B-immediate and J-immediate.
  - src2_i selection:
    - I-imm for op_imm, op_load, op_jalr, op_accel.
    - S-imm for op_store.
    - U-imm (instr[31:12], 12'b0) for op_lui, op_auipc.
    - J-imm for op_jal.
    - B-imm for op_br.
    - 0 for op_reg.
  - rd = instr[11:7], except 0 for op_br and op_store.
  - r1_i = instr[19:15], except 0 for op_lui, op_auipc, op_jal.
  - r2_i = instr[24:20] only for op_reg, op_br, op_store, op_accel; otherwise 0.
  - Unknown opcode: fields decoded as op_reg, src2_i = 0. The issue stage will never assert iq_read for it.
- Pass-through: inst_pc, instruction_i, pc_save and target_predict_i come straight from the head entry.

Test Plan:
- Basic push and pop:
  - Release reset, push addi x5,x1,-4 (0xFFC08293) at pc 0x60. Next cycle: iq_assert = 1, rd = 5, r1_i = 1, r2_i = 0, src2_i = 0xFFFFFFFC, inst_pc = 0x60.
  - Assert iq_read: iq_assert = 0 the next cycle and count returns to 0.
- Fill and order:
  - Push 8 instructions with iq_read held low: fetch_ready = 0 and count = 8. A 9th fetch_valid is dropped.
  - Pop all 8: the inst_pc order matches the push order.
  - Repeat for 3 full rounds to exercise pointer wrap.
- Simultaneous push and pop at count = 3: count stays 3. At full, the pop completes and the push is refused.
- Flush with queue at count = 5, fetch_valid and iq_read both high: next cycle count = 0, iq_assert = 0, fetch_ready = 1, and no stale entry reappears.
- Decode coverage:
  - sw x7,8(x2): rd = 0, r1_i = 2, r2_i = 7, src2_i = 8.
  - lui x3,0x12345: r1_i = 0, src2_i = 0x12345000.
  - beq x1,x2,-8: rd = 0, b_imm = 0xFFFFFFF8.
  - jal x1,+2048: j_imm = 0x800.
- Asynchronous reset: pull reset_n low between clock edges with count = 4. iq_assert and count go to 0 immediately, with no clock edge.
